// File: rtl/turn_signal_sequencer.sv
// Turn-signal scheduler: chooses manual switch control or a timed demo script
// (IDLE -> HAZARD -> LEFT -> RIGHT) and drives the light FSM plus the step display.
module turn_signal_sequencer #(
  parameter int TICK_W      = 6,
  parameter int IDLE_TICKS  = 5,
  parameter int HAZ_TICKS   = 5,
  parameter int LEFT_TICKS  = 5,
  parameter int RIGHT_TICKS = 5,
  parameter bit LOOP        = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic       demo_en,
  input  logic       start,
  input  logic       man_hazard,
  input  logic       man_enable,
  input  logic       man_lr,
  output logic [1:0] state_out,
  output logic       lr_out,
  output logic [1:0] step,
  output logic       step_done,
  output logic       busy
);

  // state  | meaning
  // MANUAL | outputs follow man_* switches; script idle
  // RUN    | script stepping on ticks
  // HOLD   | script frozen while manual hazard is on
  localparam logic [1:0] CTL_MANUAL = 2'd0;
  localparam logic [1:0] CTL_RUN    = 2'd1;
  localparam logic [1:0] CTL_HOLD   = 2'd2;

  localparam int MAX_DUR = (1 << TICK_W) - 1;

  generate
    if (IDLE_TICKS > MAX_DUR || HAZ_TICKS > MAX_DUR ||
        LEFT_TICKS > MAX_DUR || RIGHT_TICKS > MAX_DUR) begin : g_dur_check
      $error("turn_signal_sequencer: step duration does not fit in TICK_W bits");
    end
  endgenerate

  // A zero duration still lasts one tick.
  localparam logic [TICK_W-1:0] LAST_IDLE  = TICK_W'((IDLE_TICKS  < 1 ? 1 : IDLE_TICKS)  - 1);
  localparam logic [TICK_W-1:0] LAST_HAZ   = TICK_W'((HAZ_TICKS   < 1 ? 1 : HAZ_TICKS)   - 1);
  localparam logic [TICK_W-1:0] LAST_LEFT  = TICK_W'((LEFT_TICKS  < 1 ? 1 : LEFT_TICKS)  - 1);
  localparam logic [TICK_W-1:0] LAST_RIGHT = TICK_W'((RIGHT_TICKS < 1 ? 1 : RIGHT_TICKS) - 1);

  logic [1:0]        ctl;
  logic [TICK_W-1:0] cnt;
  logic [TICK_W-1:0] cnt_last;
  logic [1:0]        step_nxt;

  always_comb begin
    cnt_last = LAST_IDLE;
    case (step)
      2'd0:    cnt_last = LAST_IDLE;
      2'd1:    cnt_last = LAST_HAZ;
      2'd2:    cnt_last = LAST_LEFT;
      default: cnt_last = LAST_RIGHT;
    endcase
  end

  assign step_nxt = step + 2'd1;

  // {state_out, lr_out} for each script step
  function automatic logic [2:0] step_drive(input logic [1:0] s);
    case (s)
      2'd0:    return 3'b00_0;
      2'd1:    return 3'b01_0;
      2'd2:    return 3'b10_0;
      default: return 3'b10_1;
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      ctl       <= CTL_MANUAL;
      state_out <= 2'b00;
      lr_out    <= 1'b0;
      step      <= 2'd0;
      cnt       <= '0;
      step_done <= 1'b0;
      busy      <= 1'b0;
    end else begin
      step_done <= 1'b0;
      case (ctl)
        CTL_MANUAL: begin
          state_out <= man_hazard ? 2'b01 : (man_enable ? 2'b10 : 2'b00);
          lr_out    <= man_lr;
          if (start && demo_en) begin
            step <= 2'd0;
            cnt  <= '0;
            busy <= 1'b1;
            if (man_hazard) begin
              ctl       <= CTL_HOLD;
              state_out <= 2'b01;
              lr_out    <= 1'b0;
            end else begin
              ctl                 <= CTL_RUN;
              {state_out, lr_out} <= step_drive(2'd0);
            end
          end
        end
        CTL_RUN: begin
          if (!demo_en) begin
            ctl  <= CTL_MANUAL;
            step <= 2'd0;
            cnt  <= '0;
            busy <= 1'b0;
          end else if (man_hazard) begin
            ctl       <= CTL_HOLD;
            state_out <= 2'b01;
          end else if (start) begin
            step                <= 2'd0;
            cnt                 <= '0;
            {state_out, lr_out} <= step_drive(2'd0);
          end else if (tick) begin
            if (cnt == cnt_last) begin
              cnt       <= '0;
              step_done <= 1'b1;
              if (step == 2'd3 && !LOOP) begin
                // Script finished: outputs track the switches from the next clk on.
                ctl  <= CTL_MANUAL;
                step <= 2'd0;
                busy <= 1'b0;
              end else begin
                step                <= step_nxt;
                {state_out, lr_out} <= step_drive(step_nxt);
              end
            end else begin
              cnt <= cnt + TICK_W'(1);
            end
          end
        end
        CTL_HOLD: begin
          if (!demo_en) begin
            ctl  <= CTL_MANUAL;
            step <= 2'd0;
            cnt  <= '0;
            busy <= 1'b0;
          end else if (!man_hazard) begin
            ctl                 <= CTL_RUN;
            {state_out, lr_out} <= step_drive(step);
          end
        end
        default: begin
          ctl  <= CTL_MANUAL;
          busy <= 1'b0;
        end
      endcase
    end
  end

endmodule
